// File: rtl/seg7_pkg.sv
// Shared segment encoding for the seven-segment receive path.
// Segment bit order matches the drivers: bit0=a ... bit6=g.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_0     = 7'h3F;  // abcdef
  localparam logic [6:0] GLYPH_1     = 7'h06;  // bc
  localparam logic [6:0] GLYPH_2     = 7'h5B;  // abdeg
  localparam logic [6:0] GLYPH_3     = 7'h4F;  // abcdg
  localparam logic [6:0] GLYPH_4     = 7'h66;  // bcfg
  localparam logic [6:0] GLYPH_5     = 7'h6D;  // acdfg
  localparam logic [6:0] GLYPH_6     = 7'h7D;  // acdefg
  localparam logic [6:0] GLYPH_7     = 7'h07;  // abc
  localparam logic [6:0] GLYPH_8     = 7'h7F;  // abcdefg
  localparam logic [6:0] GLYPH_9     = 7'h67;  // abcfg
  localparam logic [6:0] GLYPH_A     = 7'h77;  // abcefg
  localparam logic [6:0] GLYPH_B     = 7'h7C;  // cdefg
  localparam logic [6:0] GLYPH_C     = 7'h39;  // adef
  localparam logic [6:0] GLYPH_D     = 7'h5E;  // bcdeg
  localparam logic [6:0] GLYPH_E     = 7'h79;  // adefg
  localparam logic [6:0] GLYPH_F     = 7'h71;  // aefg
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_EN = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational segment-pattern to hex lookup; anything outside the
// glyph set (other than all-off) is flagged as not legal.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       is_blank,
  output logic [3:0] value
);

  // Glyph table lookup
  always_comb begin
    legal    = 1'b1;
    is_blank = 1'b0;
    value    = 4'h0;
    case (seg)
      GLYPH_0:     value = 4'h0;
      GLYPH_1:     value = 4'h1;
      GLYPH_2:     value = 4'h2;
      GLYPH_3:     value = 4'h3;
      GLYPH_4:     value = 4'h4;
      GLYPH_5:     value = 4'h5;
      GLYPH_6:     value = 4'h6;
      GLYPH_7:     value = 4'h7;
      GLYPH_8:     value = 4'h8;
      GLYPH_9:     value = 4'h9;
      GLYPH_A:     value = 4'hA;
      GLYPH_B:     value = 4'hB;
      GLYPH_C:     value = 4'hC;
      GLYPH_D:     value = 4'hD;
      GLYPH_E:     value = 4'hE;
      GLYPH_F:     value = 4'hF;
      GLYPH_BLANK: is_blank = 1'b1;
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a scanned seven-segment bus.
// A digit is captured once its sampled pattern has been stable for
// STABLE_CYCLES consecutive samples, which rejects scan-edge ghosting.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   WAIT_EN | sampled digit enable not one-hot, nothing to settle
//   SETTLE  | one-hot pattern counting towards the stable dwell
//   HELD    | pattern already captured, waiting for it to change
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                seg,
  input  logic                      dp,
  input  logic [NUM_DIGITS-1:0]     digit,
  output logic [4*NUM_DIGITS-1:0]   hex,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic [NUM_DIGITS-1:0]     blank,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      frame_valid,
  output logic                      err
);

  localparam int SMP_W = NUM_DIGITS + 8;
  // Capture happens on the edge where the counter would reach this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]       smp, prev;
  logic [NUM_DIGITS-1:0]  smp_digit;
  logic                   smp_dp;
  logic [6:0]             smp_seg;
  scan_state_e            state;
  logic [CNT_W-1:0]       counter;
  logic [NUM_DIGITS-1:0]  seen, seen_next;

  logic smp_changed, smp_onehot, enter_settle, settle_done, capture_now;
  logic cap_legal, frame_done;
  logic glyph_legal, glyph_blank;
  logic [3:0] glyph_value;

  assign smp_digit = smp[SMP_W-1:8];
  assign smp_dp    = smp[7];
  assign smp_seg   = smp[6:0];

  seg7_to_hex u_seg7_to_hex (
    .seg      (smp_seg),
    .legal    (glyph_legal),
    .is_blank (glyph_blank),
    .value    (glyph_value)
  );

  // Settle/capture decisions for the current sample
  always_comb begin
    smp_changed  = (smp != prev);
    smp_onehot   = $onehot(smp_digit);
    enter_settle = smp_onehot && ((state == WAIT_EN) || smp_changed);
    settle_done  = (state == SETTLE) && !smp_changed && ((counter + 8'd1) == CNT_LAST);
    // With a dwell of one sample the capture coincides with entering SETTLE.
    capture_now  = settle_done || (enter_settle && (STABLE_CYCLES == 1));
    cap_legal    = capture_now && glyph_legal;
    seen_next    = seen | (cap_legal ? smp_digit : '0);
    frame_done   = cap_legal && (&seen_next);
  end

  // Input sampling and settle FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      smp     <= '0;
      prev    <= '0;
      state   <= WAIT_EN;
      counter <= '0;
    end else begin
      smp  <= {digit, dp, seg};
      prev <= smp;
      case (state)
        WAIT_EN: begin
          counter <= '0;
          if (enter_settle) state <= capture_now ? HELD : SETTLE;
        end
        SETTLE, HELD: begin
          if (smp_changed) begin
            counter <= '0;
            if (!smp_onehot)      state <= WAIT_EN;
            else if (capture_now) state <= HELD;
            else                  state <= SETTLE;
          end else if (state == SETTLE) begin
            counter <= counter + 8'd1;
            if (settle_done) state <= HELD;
          end
        end
        default: begin
          state   <= WAIT_EN;
          counter <= '0;
        end
      endcase
    end
  end

  // Capture registers, frame tracking and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hex         <= '0;
      dp_out      <= '0;
      blank       <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err         <= capture_now && !glyph_legal;
      frame_valid <= frame_done;
      seen        <= frame_done ? '0 : seen_next;
      if (cap_legal) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (smp_digit[i]) begin
            dp_out[i]      <= smp_dp;
            digit_valid[i] <= 1'b1;
            if (glyph_blank) begin
              blank[i] <= 1'b1;
            end else begin
              blank[i]       <= 1'b0;
              hex[4*i +: 4]  <= glyph_value;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus
// randomized scanning, compared every cycle against a run-length model.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [6:0]        seg = '0;
  logic              dp = 1'b0;
  logic [ND-1:0]     digit = '0;
  logic [4*ND-1:0]   hex;
  logic [ND-1:0]     dp_out, blank, digit_valid;
  logic              frame_valid, err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .dp          (dp),
    .digit       (digit),
    .hex         (hex),
    .dp_out      (dp_out),
    .blank       (blank),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyphs written as the lit segment letters
  string glyph_def [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int v);
    string s;
    logic [6:0] m;
    int idx;
    s = glyph_def[v];
    m = '0;
    for (int i = 0; i < s.len(); i++) begin
      idx = int'(s[i]) - 97;
      m[idx] = 1'b1;
    end
    return m;
  endfunction

  // Behavioural model: a one-hot sample captured when it has sat in the
  // sample register for exactly SC consecutive edges.
  logic [3:0]      m_hex [ND];
  logic [ND-1:0]   m_dp, m_blank, m_valid, m_seen;
  logic            m_frame, m_err;
  logic [ND+7:0]   m_smp;
  int              m_run;
  bit              model_live = 0;

  always @(posedge clk) begin
    logic [ND+7:0] nv;
    logic [ND-1:0] d;
    int idx, val;
    if (rst) begin
      for (int i = 0; i < ND; i++) m_hex[i] = 4'h0;
      m_dp = '0; m_blank = '0; m_valid = '0; m_seen = '0;
      m_frame = 1'b0; m_err = 1'b0;
      m_smp = '0; m_run = 1;
      model_live = 1;
    end else begin
      m_frame = 1'b0;
      m_err = 1'b0;
      d = m_smp[ND+7:8];
      if ($countones(d) == 1 && m_run == SC) begin
        idx = 0;
        for (int i = 0; i < ND; i++) if (d[i]) idx = i;
        val = -1;
        for (int v = 0; v < 16; v++) if (glyph(v) == m_smp[6:0]) val = v;
        if (m_smp[6:0] == 7'h00) begin
          m_blank[idx] = 1'b1;
          m_dp[idx] = m_smp[7];
          m_valid[idx] = 1'b1;
          m_seen[idx] = 1'b1;
        end else if (val >= 0) begin
          m_hex[idx] = 4'(val);
          m_blank[idx] = 1'b0;
          m_dp[idx] = m_smp[7];
          m_valid[idx] = 1'b1;
          m_seen[idx] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        if (&m_seen) begin
          m_frame = 1'b1;
          m_seen = '0;
        end
      end
      nv = {digit, dp, seg};
      if (nv == m_smp) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_smp = nv;
        m_run = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [4*ND-1:0] exp_hex;
    if (model_live) begin
      for (int i = 0; i < ND; i++) exp_hex[4*i +: 4] = m_hex[i];
      chk("hex", 32'(hex), 32'(exp_hex));
      chk("dp_out", 32'(dp_out), 32'(m_dp));
      chk("blank", 32'(blank), 32'(m_blank));
      chk("digit_valid", 32'(digit_valid), 32'(m_valid));
      chk("frame_valid", 32'(frame_valid), 32'(m_frame));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  int n_frame = 0;
  int n_err = 0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_frame++;
    if (err === 1'b1) n_err++;
  end

  task automatic drive(input logic [ND-1:0] d, input logic [6:0] s, input logic p, input int n);
    digit = d;
    seg = s;
    dp = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hex"}, 32'(hex), 32'h0);
    chk({tag, "_dp_out"}, 32'(dp_out), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'h0);
    chk({tag, "_digit_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    int first, f0, e0;
    logic [ND-1:0] d;
    logic [6:0] s;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single digit showing 7 with dp: capture 4 edges after sampling edge
    digit = 4'b0001; seg = 7'h07; dp = 1'b1;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (digit_valid[0] && first < 0) first = c;
    end
    chk("t1_latency", 32'(first), 32'd5);
    chk("t1_hex0", 32'(hex[3:0]), 32'h7);
    chk("t1_dp0", 32'(dp_out[0]), 32'h1);
    chk("t1_valid", 32'(digit_valid), 32'h1);
    chk("t1_err_count", 32'(n_err), 32'd0);

    // Full scan 1,2,3,4 twice
    f0 = n_frame;
    for (int i = 0; i < ND; i++) drive(ND'(1 << i), glyph(i + 1), 1'b0, 6);
    chk("t2_hex", 32'(hex), 32'h4321);
    chk("t2_frames1", 32'(n_frame - f0), 32'd1);
    for (int i = 0; i < ND; i++) drive(ND'(1 << i), glyph(i + 1), 1'b0, 6);
    chk("t2_frames2", 32'(n_frame - f0), 32'd2);

    // Illegal pattern on digit 2
    e0 = n_err; f0 = n_frame;
    drive(4'b0100, 7'b1111110, 1'b0, 8);
    chk("t3_err_pulses", 32'(n_err - e0), 32'd1);
    chk("t3_hex", 32'(hex), 32'h4321);
    chk("t3_valid", 32'(digit_valid), 32'hF);
    chk("t3_frames", 32'(n_frame - f0), 32'd0);

    // Blank after A on digit 1
    drive(4'b0010, glyph(10), 1'b0, 6);
    drive(4'b0010, 7'h00, 1'b1, 6);
    chk("t5_blank1", 32'(blank[1]), 32'h1);
    chk("t5_hex1", 32'(hex[7:4]), 32'hA);
    chk("t5_valid1", 32'(digit_valid[1]), 32'h1);
    chk("t5_dp1", 32'(dp_out[1]), 32'h1);

    // Too-short dwell and non-one-hot enables never capture
    do_reset();
    e0 = n_err; f0 = n_frame;
    for (int i = 0; i < 10; i++) drive(ND'(1 << (i % ND)), glyph(i), 1'(i), 3);
    drive(4'b0011, glyph(8), 1'b0, 10);
    drive(4'b0000, glyph(8), 1'b0, 10);
    chk("t4_valid", 32'(digit_valid), 32'h0);
    chk("t4_frames", 32'(n_frame - f0), 32'd0);
    chk("t4_errs", 32'(n_err - e0), 32'd0);

    // Reset mid-frame, then a full scan
    drive(4'b0001, glyph(5), 1'b0, 6);
    drive(4'b0010, glyph(6), 1'b0, 6);
    chk("t6_partial_valid", 32'(digit_valid), 32'h3);
    do_reset();
    chk_all_zero("t6_after_rst");
    f0 = n_frame;
    for (int i = 0; i < ND - 1; i++) drive(ND'(1 << i), glyph(i + 5), 1'b0, 6);
    chk("t6_frames_3of4", 32'(n_frame - f0), 32'd0);
    drive(4'b1000, glyph(8), 1'b0, 6);
    chk("t6_frames_4of4", 32'(n_frame - f0), 32'd1);
    chk("t6_hex", 32'(hex), 32'h8765);

    // Randomized scanning against the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) d = ND'($urandom);
      else d = ND'(1 << $urandom_range(0, ND - 1));
      case ($urandom_range(0, 9))
        0: s = 7'($urandom);
        1: s = 7'h00;
        default: s = glyph($urandom_range(0, 15));
      endcase
      drive(d, s, 1'($urandom), $urandom_range(1, 8));
    end
    drive('0, 7'h00, 1'b0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Observes a time-multiplexed seven-segment display bus (segment lines, decimal point, one-hot digit enables) and recovers the hexadecimal value shown on each digit. It is the receive-side counterpart of our hex-to-segment decoders. It sits between a scanned display driver and logic or test harnesses that need the displayed value back as binary, for example loopback checking of display paths. Each digit is captured only after its pattern has been stable for a programmable dwell, which rejects ghosting at scan transitions.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; enable and output widths scale with it.
- STABLE_CYCLES, 4: consecutive identical samples required before a capture; legal range 1..255.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- seg  in  7  segment lines, active-high; bit0=a … bit6=g.
- dp  in  1  decimal point, active-high.
- digit  in  NUM_DIGITS  digit enables, active-high; exactly one bit set selects a digit.
- hex  out  4*NUM_DIGITS  captured values; digit i is in [4i+3:4i].
- dp_out  out  NUM_DIGITS  captured decimal point per digit.
- blank  out  NUM_DIGITS  1 = digit last captured as all-segments-off.
- digit_valid  out  NUM_DIGITS  sticky; digit captured at least once since reset.
- frame_valid  out  1  one-cycle pulse; every digit captured since the previous pulse.
- err  out  1  one-cycle pulse; a stable pattern was not a legal glyph.

## Operation
- Legal glyphs use our standard segment set:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc.
  - 8=abcdefg, 9=abcfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
  - seg==0 is legal blank.
- Input stage: {digit, dp, seg} registered every cycle into smp; prev holds the previous smp.
- FSM, three states:
  - WAIT_EN: smp.digit not one-hot, counter 0. Goes to SETTLE when smp.digit is one-hot.
  - SETTLE: counter increments while smp==prev. When counter reaches STABLE_CYCLES-1 with smp==prev (or immediately, for STABLE_CYCLES=1), capture and go to HELD.
  - HELD: no further capture while smp==prev.
  - From SETTLE or HELD, any change: counter 0, then SETTLE if smp.digit is one-hot, else WAIT_EN.
- Capture into digit i (selected by smp.digit):
  - Glyph 0–F: hex[i]=value, dp_out[i]=dp, blank[i]=0, digit_valid[i]=1, seen[i]=1.
  - Blank: blank[i]=1, dp_out[i]=dp, hex[i] unchanged, digit_valid[i]=1, seen[i]=1.
  - Illegal: err=1 for one cycle; hex, dp_out, blank, digit_valid and seen all unchanged.
- seen is an internal NUM_DIGITS bit set. On the capture edge that makes it all-ones, frame_valid=1 and seen clears to 0 on that same edge.
- Re-capturing an already-seen digit does not advance the frame.

## Timing
- Reset values: hex=0, dp_out=0, blank=0, digit_valid=0, frame_valid=0, err=0, seen=0, counter=0, state=WAIT_EN, smp/prev=0.
- Latency: an input stable before edge k is in smp after edge k. Capture registers, err and frame_valid update at edge k+STABLE_CYCLES.
- Outputs are registered; no combinational path from inputs to outputs.
- A change during SETTLE aborts the capture with no partial update.
- A one-cycle glitch in HELD causes a fresh settle and re-capture of the same digit, which is harmless.
- rst mid-settle or mid-frame clears everything on that edge; the first capture is possible at edge rst-deassert+STABLE_CYCLES+1.
- err and frame_valid can never assert on the same edge (an illegal capture never sets seen).
- Counter width: 8 bits.

## Structure
- Package seg7_pkg:
  - segment bit-index constants SEG_A..SEG_G;
  - 7-bit glyph constants GLYPH_0..GLYPH_F and GLYPH_BLANK;
  - typedef for the FSM state enum.
- Sub-module seg7_to_hex: combinational pattern → {legal, is_blank, value[3:0]} lookup. The top-level holds the FSM, counter and capture registers.

## Test plan
- rst, then digit=0001, seg=GLYPH_7, dp=1 held for 10 cycles (STABLE_CYCLES=4) → hex[3:0]=7, dp_out[0]=1, digit_valid=0001 exactly 4 edges after the sampling edge; exactly one capture.
- Scan digits 0..3 showing 1,2,3,4, dwell 6 cycles each → hex=16'h4321, a single frame_valid pulse on digit 3's capture edge. A second identical scan → a second pulse.
- digit=0100, seg=7'b1111110 (illegal) held → err pulses once; hex, digit_valid and frame progress unchanged.
- Pattern held for only 3 cycles between changes → no capture and no pulses. digit=0011 or 0000 held → no capture (state stays WAIT_EN).
- digit=0010 held blank after showing A → blank[1]=1, hex[7:4]=A retained, digit_valid[1]=1.
- rst asserted after 2 of 4 digits captured, then the full scan → all outputs zero after reset, and frame_valid fires only after all 4 digits are captured post-reset.
